// File: rtl/bus_drive_arbiter.sv
// -----------------------------------------------------------------------------
// bus_drive_arbiter
//
// Purpose:
//   Lets NUM_CH sources share one WIDTH-bit tri-state bus. Requests are
//   arbitrated round-robin. The winner's data is latched on the grant edge and
//   driven for HOLD_CYC cycles. A TURN_CYC high-Z gap follows before the next
//   grant. All outputs come from registers, and bus_out is high-Z whenever
//   bus_oe is low.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [NUM_CH]        per-channel level request
//   data_in    in   [NUM_CH*WIDTH]  channel i data at [i*WIDTH +: WIDTH]
//   bus_busy   in   external driver owns the bus; new grants are held off
//   bus_out    out  [WIDTH]   latched data while bus_oe=1, all-Z otherwise
//   bus_oe     out  registered drive enable (1 iff grant != 0)
//   grant      out  [NUM_CH]  one-hot current owner, zero when not driving
//   ack        out  [NUM_CH]  one-cycle pulse on the owner's last drive cycle
//   owner_id   out  [clog2(NUM_CH)] index of the last/current owner
//   dbg_state  out  [2]       FSM state (0=IDLE, 1=DRIVE, 2=TURN)
//
// Handshake: a request is a level on req[i]. It is sampled only in IDLE, and
// only while bus_busy=0. The transfer that follows runs to completion
// regardless of req or bus_busy, and ack[i] marks its final drive cycle.
// -----------------------------------------------------------------------------
module bus_drive_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NUM_CH   = 4,
    parameter int HOLD_CYC = 1,
    parameter int TURN_CYC = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH*WIDTH-1:0]     data_in,
    input  logic                        bus_busy,
    output logic [WIDTH-1:0]            bus_out,
    output logic                        bus_oe,
    output logic [NUM_CH-1:0]           grant,
    output logic [NUM_CH-1:0]           ack,
    output logic [$clog2(NUM_CH)-1:0]   owner_id,
    output logic [1:0]                  dbg_state
);

    localparam int IDW = $clog2(NUM_CH);
    // The counters hold "cycles remaining minus one". Their minimum width is 1.
    localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int TCW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYC - 1);
    localparam logic [TCW-1:0] TURN_LOAD = TCW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [WIDTH-1:0]    data_q,   data_d;
    logic                oe_q,     oe_d;
    logic [NUM_CH-1:0]   grant_q,  grant_d;
    logic [NUM_CH-1:0]   ack_q,    ack_d;
    logic [IDW-1:0]      owner_q,  owner_d;
    logic [IDW-1:0]      last_q,   last_d;
    logic [HCW-1:0]      hold_q,   hold_d;
    logic [TCW-1:0]      turn_q,   turn_d;

    // Round-robin pick. The search order is last+1 .. NUM_CH-1, then
    // 0 .. last. Split it into two fixed-priority searches:
    //   "hi" looks at channels above the pointer.
    //   "lo" looks at channels at or below the pointer.
    // A hi hit always beats a lo hit. Each loop runs downward, so the lowest
    // matching index is written last and wins. Only indices below NUM_CH are
    // examined, so the pointer wraps cleanly for any NUM_CH.
    logic                hi_found, lo_found, win_valid;
    logic [IDW-1:0]      hi_id,    lo_id,    win_id;
    logic [NUM_CH-1:0]   hi_oh,    lo_oh,    win_oh;
    logic [WIDTH-1:0]    hi_data,  lo_data,  win_data;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        hi_oh    = '0;
        lo_oh    = '0;
        hi_data  = '0;
        lo_data  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last_q)) begin
                    hi_found   = 1'b1;
                    hi_id      = IDW'(i);
                    hi_oh      = '0;
                    hi_oh[i]   = 1'b1;
                    hi_data    = data_in[i*WIDTH +: WIDTH];
                end else begin
                    lo_found   = 1'b1;
                    lo_id      = IDW'(i);
                    lo_oh      = '0;
                    lo_oh[i]   = 1'b1;
                    lo_data    = data_in[i*WIDTH +: WIDTH];
                end
            end
        end
        win_valid = hi_found | lo_found;
        win_id    = hi_found ? hi_id   : lo_id;
        win_oh    = hi_found ? hi_oh   : lo_oh;
        win_data  = hi_found ? hi_data : lo_data;
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        oe_d    = oe_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        turn_d  = turn_q;

        case (state_q)
            S_IDLE: begin
                if (win_valid && !bus_busy) begin
                    data_d  = win_data;
                    grant_d = win_oh;
                    owner_d = win_id;
                    last_d  = win_id;
                    oe_d    = 1'b1;
                    hold_d  = HOLD_LOAD;
                    // With a single-cycle hold, the first drive cycle is
                    // also the last one, so ack starts with the grant.
                    ack_d   = (HOLD_CYC == 1) ? win_oh : '0;
                    state_d = S_DRIVE;
                end
            end

            S_DRIVE: begin
                if (hold_q == '0) begin
                    oe_d    = 1'b0;
                    grant_d = '0;
                    ack_d   = '0;
                    if (TURN_CYC > 0) begin
                        turn_d  = TURN_LOAD;
                        state_d = S_TURN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                    // Raise ack for the cycle in which hold will read zero.
                    ack_d  = (hold_q == HCW'(1)) ? grant_q : '0;
                end
            end

            S_TURN: begin
                if (turn_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                oe_d    = 1'b0;
                grant_d = '0;
                ack_d   = '0;
            end
        endcase
    end

    // State registers. Reset clears oe_q asynchronously, so the bus is
    // released without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            oe_q    <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            owner_q <= '0;
            last_q  <= IDW'(NUM_CH - 1);
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
        end
    end

    assign bus_out   = oe_q ? data_q : {WIDTH{1'bz}};
    assign bus_oe    = oe_q;
    assign grant     = grant_q;
    assign ack       = ack_q;
    assign owner_id  = owner_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_drive_arbiter.sv
module tb_bus_drive_arbiter;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- main DUT: 4 ch, hold 1, turn 1 ----------------
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        bus_busy;
  wire  [7:0]  bus_out;
  logic        bus_oe;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [1:0]  owner_id;
  logic [1:0]  dbg_state;

  bus_drive_arbiter #(.WIDTH(8), .NUM_CH(4), .HOLD_CYC(1), .TURN_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .bus_busy(bus_busy),
    .bus_out(bus_out), .bus_oe(bus_oe), .grant(grant), .ack(ack),
    .owner_id(owner_id), .dbg_state(dbg_state)
  );

  // ---------------- hold-3 DUT ----------------
  logic [3:0]  h_req;
  logic [31:0] h_data;
  logic        h_busy;
  wire  [7:0]  h_bus;
  logic        h_oe;
  logic [3:0]  h_grant;
  logic [3:0]  h_ack;
  logic [1:0]  h_owner;
  logic [1:0]  h_state;

  bus_drive_arbiter #(.WIDTH(8), .NUM_CH(4), .HOLD_CYC(3), .TURN_CYC(1)) u_h3 (
    .clk(clk), .rst_n(rst_n), .req(h_req), .data_in(h_data), .bus_busy(h_busy),
    .bus_out(h_bus), .bus_oe(h_oe), .grant(h_grant), .ack(h_ack),
    .owner_id(h_owner), .dbg_state(h_state)
  );

  // ---------------- 3-channel DUT ----------------
  logic [2:0]  n_req;
  logic [23:0] n_data;
  logic        n_busy;
  wire  [7:0]  n_bus;
  logic        n_oe;
  logic [2:0]  n_grant;
  logic [2:0]  n_ack;
  logic [1:0]  n_owner;
  logic [1:0]  n_state;

  bus_drive_arbiter #(.WIDTH(8), .NUM_CH(3), .HOLD_CYC(1), .TURN_CYC(1)) u_n3 (
    .clk(clk), .rst_n(rst_n), .req(n_req), .data_in(n_data), .bus_busy(n_busy),
    .bus_out(n_bus), .bus_oe(n_oe), .grant(n_grant), .ack(n_ack),
    .owner_id(n_owner), .dbg_state(n_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        busy;
    logic        oe;
    logic [7:0]  bus;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] r, input logic [31:0] d,
                     input logic b, input logic oe, input logic [7:0] bus,
                     input logic [3:0] g, input logic [3:0] a, input logic [1:0] o,
                     input logic [1:0] st);
    vec_t v;
    v.rst = rst; v.req = r; v.data = d; v.busy = b; v.oe = oe; v.bus = bus;
    v.grant = g; v.ack = a; v.owner = o; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic idle_pair(input logic [3:0] r, input logic [31:0] d, input logic b,
                           input logic [1:0] o);
    add(0, r, d, b, 0, 8'h00, 4'b0000, 4'b0000, o, ST_TURN);
    add(0, r, d, b, 0, 8'h00, 4'b0000, 4'b0000, o, ST_IDLE);
  endtask

  initial begin
    logic [31:0] d2;
    logic [31:0] d3;
    logic [31:0] dfa;
    logic [31:0] dcc;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    req = '0; data_in = '0; bus_busy = 1'b0;
    h_req = '0; h_data = '0; h_busy = 1'b0;
    n_req = '0; n_data = '0; n_busy = 1'b0;

    d2  = 32'h44332211;
    d3  = 32'h003C0000;
    dfa = 32'h0000BBAA;
    dcc = 32'hCC000000;

    // Single request on ch0
    add(0, 4'b0001, 32'h000000A5, 0, 1, 8'hA5, 4'b0001, 4'b0001, 2'd0, ST_DRIVE);
    idle_pair(4'b0000, 32'h000000A5, 0, 2'd0);
    // All channels requesting: rotation 0,1,2,3,0 with 3-cycle spacing
    add(1, 4'b1111, d2, 0, 1, 8'h11, 4'b0001, 4'b0001, 2'd0, ST_DRIVE);
    idle_pair(4'b1111, d2, 0, 2'd0);
    add(0, 4'b1111, d2, 0, 1, 8'h22, 4'b0010, 4'b0010, 2'd1, ST_DRIVE);
    idle_pair(4'b1111, d2, 0, 2'd1);
    add(0, 4'b1111, d2, 0, 1, 8'h33, 4'b0100, 4'b0100, 2'd2, ST_DRIVE);
    idle_pair(4'b1111, d2, 0, 2'd2);
    add(0, 4'b1111, d2, 0, 1, 8'h44, 4'b1000, 4'b1000, 2'd3, ST_DRIVE);
    idle_pair(4'b1111, d2, 0, 2'd3);
    add(0, 4'b1111, d2, 0, 1, 8'h11, 4'b0001, 4'b0001, 2'd0, ST_DRIVE);
    idle_pair(4'b0000, d2, 0, 2'd0);
    // bus_busy holds off ch2 for five cycles, then the grant follows at once
    for (int k = 0; k < 5; k++)
      add(0, 4'b0100, d3, 1, 0, 8'h00, 4'b0000, 4'b0000, 2'd0, ST_IDLE);
    add(0, 4'b0100, d3, 0, 1, 8'h3C, 4'b0100, 4'b0100, 2'd2, ST_DRIVE);
    idle_pair(4'b0000, d3, 0, 2'd2);
    // Pointer at 2: req 0011 wraps to ch0, then ch1
    add(0, 4'b0011, dfa, 0, 1, 8'hAA, 4'b0001, 4'b0001, 2'd0, ST_DRIVE);
    idle_pair(4'b0011, dfa, 0, 2'd0);
    add(0, 4'b0011, dfa, 0, 1, 8'hBB, 4'b0010, 4'b0010, 2'd1, ST_DRIVE);
    idle_pair(4'b0000, dfa, 0, 2'd1);
    // bus_busy rising mid-transfer does not disturb it
    add(0, 4'b1000, dcc, 0, 1, 8'hCC, 4'b1000, 4'b1000, 2'd3, ST_DRIVE);
    idle_pair(4'b1000, dcc, 1, 2'd3);
    add(0, 4'b1000, dcc, 1, 0, 8'h00, 4'b0000, 4'b0000, 2'd3, ST_IDLE);

    // Reset state
    #7;
    rst_n = 1'b1;
    #1;
    chk("reset bus_oe", 32'(bus_oe), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset owner_id", 32'(owner_id), 32'd0);
    chk("reset state", 32'(dbg_state), 32'(ST_IDLE));

    // Table loop: inputs are applied one time unit after an edge and the
    // outputs are checked one time unit after the next edge.
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      req      = tbl[i].req;
      data_in  = tbl[i].data;
      bus_busy = tbl[i].busy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d bus_oe", i), 32'(bus_oe), 32'(tbl[i].oe));
      if (tbl[i].oe) chk($sformatf("v%0d bus_out", i), 32'(bus_out), 32'(tbl[i].bus));
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("v%0d ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("v%0d owner_id", i), 32'(owner_id), 32'(tbl[i].owner));
      chk($sformatf("v%0d state", i), 32'(dbg_state), 32'(tbl[i].st));
    end
    req = '0;
    bus_busy = 1'b0;

    // HOLD_CYC=3: the latched value is driven for three cycles and ack
    // appears only in the third. Neither dropping req nor changing data
    // during the drive has any effect.
    do_reset();
    h_req  = 4'b0010;
    h_data = 32'h00005A00;
    @(posedge clk); #1;
    chk("h3 c1 oe", 32'(h_oe), 32'd1);
    chk("h3 c1 bus", 32'(h_bus), 32'h5A);
    chk("h3 c1 grant", 32'(h_grant), 32'b0010);
    chk("h3 c1 ack", 32'(h_ack), 32'd0);
    h_req  = 4'b0000;
    h_data = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("h3 c2 bus", 32'(h_bus), 32'h5A);
    chk("h3 c2 grant", 32'(h_grant), 32'b0010);
    chk("h3 c2 ack", 32'(h_ack), 32'd0);
    @(posedge clk); #1;
    chk("h3 c3 bus", 32'(h_bus), 32'h5A);
    chk("h3 c3 oe", 32'(h_oe), 32'd1);
    chk("h3 c3 ack", 32'(h_ack), 32'b0010);
    @(posedge clk); #1;
    chk("h3 end oe", 32'(h_oe), 32'd0);
    chk("h3 end grant", 32'(h_grant), 32'd0);
    chk("h3 end ack", 32'(h_ack), 32'd0);
    chk("h3 end state", 32'(h_state), 32'(ST_TURN));
    @(posedge clk); #1;
    chk("h3 idle state", 32'(h_state), 32'(ST_IDLE));
    h_data = '0;

    // Asynchronous reset during DRIVE releases the bus without a clock edge
    do_reset();
    req     = 4'b0001;
    data_in = 32'h000000A5;
    @(posedge clk); #1;
    chk("arst pre oe", 32'(bus_oe), 32'd1);
    chk("arst pre grant", 32'(grant), 32'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst oe", 32'(bus_oe), 32'd0);
    chk("arst grant", 32'(grant), 32'd0);
    chk("arst ack", 32'(ack), 32'd0);
    chk("arst state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n   = 1'b1;
    req     = 4'b1111;
    data_in = d2;
    @(posedge clk); #1;
    chk("arst after grant", 32'(grant), 32'b0001);
    chk("arst after bus", 32'(bus_out), 32'h11);
    chk("arst after owner", 32'(owner_id), 32'd0);
    req = '0;

    // NUM_CH=3: grants rotate 0,1,2,0 and owner_id stays below 3
    do_reset();
    n_req  = 3'b111;
    n_data = 24'h030201;
    for (int k = 0; k < 12; k++) begin
      int exp_ch;
      exp_ch = (k / 3) % 3;
      @(posedge clk); #1;
      chk($sformatf("n3 k%0d owner", k), 32'(n_owner), 32'(exp_ch));
      if (k % 3 == 0) begin
        chk($sformatf("n3 k%0d grant", k), 32'(n_grant), 32'(1 << exp_ch));
        chk($sformatf("n3 k%0d bus", k), 32'(n_bus), 32'(exp_ch + 1));
      end else begin
        chk($sformatf("n3 k%0d grant", k), 32'(n_grant), 32'd0);
        chk($sformatf("n3 k%0d oe", k), 32'(n_oe), 32'd0);
      end
    end
    n_req = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
